// File: rtl/vector_pkg.sv
// Shared definitions for the vector display-list player.
// Opcodes, entry field positions, command classes and FSM states.
package vector_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_JUMP   = 4'h1;
  localparam logic [3:0] OP_DRAW   = 4'h2;
  localparam logic [3:0] OP_TRAVEL = 4'h3;
  localparam logic [3:0] OP_SHIFT  = 4'h4;
  localparam logic [3:0] OP_END    = 4'h5;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int PRM_HI = 27;
  localparam int PRM_LO = 24;
  localparam int Y_HI   = 23;
  localparam int Y_LO   = 12;
  localparam int X_HI   = 11;
  localparam int X_LO   = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_ISSUE,
    S_FRAME_WAIT
  } state_e;

  typedef enum logic [2:0] {
    C_NOP,
    C_JUMP,
    C_DRAW,
    C_TRAVEL,
    C_SHIFT,
    C_END,
    C_HALT,
    C_BAD
  } cls_e;

  typedef struct packed {
    cls_e        cls;
    logic [3:0]  prm;
    logic [11:0] y;
    logic [11:0] x;
  } entry_t;

  typedef struct packed {
    cls_e        cls;
    logic [11:0] y;
    logic [11:0] x;
  } cmd_t;

endpackage

// File: rtl/vector_entry_decode.sv
// Combinational split of a display-list entry into
// command class, parameter and coordinates.
module vector_entry_decode
  import vector_pkg::*;
(
  input  logic [31:0] entry_i,
  output entry_t      dec_o
);

  logic [3:0] op;

  assign op = entry_i[OPC_HI:OPC_LO];

  always_comb begin
    dec_o     = '0;
    dec_o.prm = entry_i[PRM_HI:PRM_LO];
    dec_o.y   = entry_i[Y_HI:Y_LO];
    dec_o.x   = entry_i[X_HI:X_LO];
    unique case (1'b1)
      op == OP_NOP:    dec_o.cls = C_NOP;
      op == OP_JUMP:   dec_o.cls = C_JUMP;
      op == OP_DRAW:   dec_o.cls = C_DRAW;
      op == OP_TRAVEL: dec_o.cls = C_TRAVEL;
      op == OP_SHIFT:  dec_o.cls = C_SHIFT;
      op == OP_END:    dec_o.cls = C_END;
      op == OP_HALT:   dec_o.cls = C_HALT;
      default:         dec_o.cls = C_BAD;
    endcase
  end

endmodule

// File: rtl/vector_list_player.sv
// Display-list player feeding jump/draw commands to the vector control block.
// Optional completed-frame counter: VECTOR_LIST_FRAME_STATS_EN.
module vector_list_player #(
  parameter int                ADDR_W     = 10,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              frame_tick,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_data,
  input  logic              ready,
  output logic              jump,
  output logic              draw,
  output logic              travel,
  output logic [11:0]       x,
  output logic [11:0]       y,
  output logic [3:0]        shift,
  output logic              busy,
  output logic              error,
  output logic [15:0]       frame_count
);

  import vector_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  cmd_t              cmd_q, cmd_d;
  logic [11:0]       x_q, x_d;
  logic [11:0]       y_q, y_d;
  logic [3:0]        sh_q, sh_d;
  logic              trv_q, trv_d;
  logic              jmp_q, jmp_d;
  logic              drw_q, drw_d;
  logic              err_q, err_d;
  logic              rd_q, rd_d;
  logic              tick_q, tick_d;
  logic              stp_q, stp_d;
  logic              stop_now;
  logic              last;
  entry_t            dec;

  vector_entry_decode u_dec (
    .entry_i (mem_data),
    .dec_o   (dec)
  );

  assign stop_now = stop | stp_q;
  assign last     = &ptr_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    x_d     = x_q;
    y_d     = y_q;
    sh_d    = sh_q;
    trv_d   = trv_q;
    err_d   = err_q;
    jmp_d   = 1'b0;
    drw_d   = 1'b0;
    rd_d    = 1'b0;
    tick_d  = tick_q | frame_tick;
    stp_d   = stp_q | stop;
    unique case (state_q)
      S_IDLE: begin
        tick_d = 1'b0;
        stp_d  = 1'b0;
        if (start && !stop) begin
          state_d = S_FETCH;
          ptr_d   = START_ADDR;
          err_d   = 1'b0;
        end
      end
      S_FETCH: begin
        if (stop_now) begin
          state_d = S_IDLE;
        end else begin
          rd_d    = 1'b1;
          addr_d  = ptr_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: state_d = S_DECODE;
      S_DECODE: begin
        cmd_d = '{cls: dec.cls, y: dec.y, x: dec.x};
        if (dec.cls == C_HALT) begin
          state_d = S_IDLE;
        end else if (dec.cls == C_END || last) begin
          // the last slot can never fall through, so it ends the frame
          state_d = S_FRAME_WAIT;
          if (dec.cls != C_END) err_d = 1'b1;
        end else begin
          unique case (dec.cls)
            C_JUMP, C_DRAW, C_TRAVEL: begin
              state_d = S_ISSUE;
            end
            C_SHIFT: begin
              sh_d    = dec.prm;
              ptr_d   = ptr_q + ADDR_W'(1);
              state_d = S_FETCH;
            end
            C_BAD: begin
              err_d   = 1'b1;
              ptr_d   = ptr_q + ADDR_W'(1);
              state_d = S_FETCH;
            end
            default: begin
              ptr_d   = ptr_q + ADDR_W'(1);
              state_d = S_FETCH;
            end
          endcase
        end
      end
      S_ISSUE: begin
        if (ready) begin
          jmp_d   = cmd_q.cls == C_JUMP;
          drw_d   = cmd_q.cls != C_JUMP;
          trv_d   = cmd_q.cls == C_TRAVEL;
          x_d     = cmd_q.x;
          y_d     = cmd_q.y;
          ptr_d   = ptr_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_FRAME_WAIT: begin
        if (stop_now) begin
          state_d = S_IDLE;
        end else if (tick_q) begin
          tick_d  = 1'b0;
          ptr_d   = START_ADDR;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= START_ADDR;
      addr_q  <= '0;
      cmd_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sh_q    <= '0;
      trv_q   <= 1'b0;
      jmp_q   <= 1'b0;
      drw_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      tick_q  <= 1'b0;
      stp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sh_q    <= sh_d;
      trv_q   <= trv_d;
      jmp_q   <= jmp_d;
      drw_q   <= drw_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      tick_q  <= tick_d;
      stp_q   <= stp_d;
    end
  end

`ifdef VECTOR_LIST_FRAME_STATS_EN
  logic [15:0] fc_q;
  logic        fc_inc;
  logic        fc_clr;

  assign fc_clr = state_q == S_IDLE && start && !stop;
  assign fc_inc = state_q == S_DECODE &&
                  (dec.cls == C_END ||
                   (last && dec.cls != C_HALT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    fc_q <= '0;
    else if (fc_clr) fc_q <= '0;
    else if (fc_inc) fc_q <= fc_q + 16'd1;
  end

  assign frame_count = fc_q;
`else
  assign frame_count = '0;
`endif

  assign mem_addr = addr_q;
  assign mem_rd   = rd_q;
  assign jump     = jmp_q;
  assign draw     = drw_q;
  assign travel   = trv_q;
  assign x        = x_q;
  assign y        = y_q;
  assign shift    = sh_q;
  assign busy     = state_q != S_IDLE;
  assign error    = err_q;

endmodule

// File: tb/tb_vector_list_player.sv
// Directed bench for vector_list_player with a command scoreboard.
module tb_vector_list_player;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          frame_tick = 1'b0;
  logic          ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [31:0]   mem_data = '0;
  logic          jump, draw, travel;
  logic [11:0]   x, y;
  logic [3:0]    shift;
  logic          busy, error;
  logic [15:0]   frame_count;

  logic [31:0] ram [16];

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  typedef struct packed {
    logic        j;
    logic        tr;
    logic [3:0]  sh;
    logic [11:0] y;
    logic [11:0] x;
  } exp_t;

  exp_t sb[$];

  vector_list_player #(.ADDR_W(AW), .START_ADDR('0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .frame_tick  (frame_tick),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .ready       (ready),
    .jump        (jump),
    .draw        (draw),
    .travel      (travel),
    .x           (x),
    .y           (y),
    .shift       (shift),
    .busy        (busy),
    .error       (error),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd) mem_data <= ram[mem_addr];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(logic j, logic tr, logic [3:0] sh,
                              logic [11:0] xx, logic [11:0] yy);
    return '{j: j, tr: tr, sh: sh, y: yy, x: xx};
  endfunction

  function automatic logic [31:0] ent(logic [3:0] op, logic [3:0] p,
                                      logic [11:0] yy, logic [11:0] xx);
    return {op, p, yy, xx};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (jump || draw) begin
      pulses++;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {62'd0, jump, draw}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse", {jump, draw, travel, shift, y, x},
            {e.j, ~e.j, e.tr, e.sh, e.y, e.x});
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_idle(string tag);
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      step();
    end
    chk(tag, {63'd0, busy}, 64'd0);
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 16; i++) ram[i] = ent(4'h0, 4'h0, 12'd0, 12'd0);
  endtask

  initial begin
    int n;
    int rd;
    clear_ram();
    step(3);
    chk("reset_outs",
        {jump, draw, travel, x, y, shift, busy, error,
         mem_rd, mem_addr, frame_count}, 64'd0);
    reset_n = 1'b1;
    step(2);

    // basic frame, restart paced by tick
    ram[0] = ent(4'h1, 4'h0, 12'd200, 12'd100);
    ram[1] = ent(4'h2, 4'h0, 12'd400, 12'd300);
    ram[2] = ent(4'h5, 4'h0, 12'd0, 12'd0);
    ready = 1'b1;
    sb.push_back(mk(1'b1, 1'b0, 4'd0, 12'd100, 12'd200));
    sb.push_back(mk(1'b0, 1'b0, 4'd0, 12'd300, 12'd400));
    pulse_start();
    drain("frame1_drain");
    n = pulses;
    rd = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_rd) rd++;
    end
    chk("restart_waits_tick", 64'(rd), 64'd0);
    chk("busy_frame_wait", {63'd0, busy}, 64'd1);
    chk("no_pulse_frame_wait", 64'(pulses), 64'(n));
    sb.push_back(mk(1'b1, 1'b0, 4'd0, 12'd100, 12'd200));
    sb.push_back(mk(1'b0, 1'b0, 4'd0, 12'd300, 12'd400));
    pulse_tick();
    drain("frame2_drain");
    step(6);
`ifdef VECTOR_LIST_FRAME_STATS_EN
    chk("fc_two", 64'(frame_count), 64'd2);
`else
    chk("fc_tied", 64'(frame_count), 64'd0);
`endif
    pulse_stop();
    wait_idle("stop_frame_wait");
    chk("xy_held_stop", {40'd0, x, y}, {40'd0, 12'd300, 12'd400});

    // ready held low during ISSUE
    ready = 1'b0;
    clear_ram();
    ram[0] = ent(4'h1, 4'h0, 12'd8, 12'd7);
    ram[1] = ent(4'h5, 4'h0, 12'd0, 12'd0);
    sb.push_back(mk(1'b1, 1'b0, 4'd0, 12'd7, 12'd8));
    pulse_start();
    n = pulses;
    step(50);
    chk("no_pulse_ready_low", 64'(pulses), 64'(n));
    chk("xy_unchanged", {40'd0, x, y}, {40'd0, 12'd300, 12'd400});
    ready = 1'b1;
    step();
    chk("pulse_after_ready", {63'd0, jump}, 64'd1);
    step();
    chk("pulse_one_cycle", {63'd0, jump}, 64'd0);
    drain("ready_drain");
    pulse_stop();
    wait_idle("ready_idle");

    // SHIFT then TRAVEL
    clear_ram();
    ram[0] = ent(4'h4, 4'h7, 12'd0, 12'd0);
    ram[1] = ent(4'h3, 4'h0, 12'd6, 12'd5);
    ram[2] = ent(4'h5, 4'h0, 12'd0, 12'd0);
    sb.push_back(mk(1'b0, 1'b1, 4'd7, 12'd5, 12'd6));
    pulse_start();
    drain("travel_drain");
    chk("shift_held", 64'(shift), 64'd7);
    pulse_stop();
    wait_idle("travel_idle");

    // unknown opcode skipped
    clear_ram();
    ram[0] = ent(4'h9, 4'h0, 12'd0, 12'd0);
    ram[1] = ent(4'h2, 4'h0, 12'd12, 12'd11);
    ram[2] = ent(4'h5, 4'h0, 12'd0, 12'd0);
    sb.push_back(mk(1'b0, 1'b0, 4'd7, 12'd11, 12'd12));
    pulse_start();
    drain("badop_drain");
    chk("err_unknown", {63'd0, error}, 64'd1);
    pulse_stop();
    wait_idle("badop_idle");
    chk("err_sticky", {63'd0, error}, 64'd1);
    sb.push_back(mk(1'b0, 1'b0, 4'd7, 12'd11, 12'd12));
    pulse_start();
    chk("start_clears_err", {63'd0, error}, 64'd0);
    drain("badop_drain2");
    pulse_stop();
    wait_idle("badop_idle2");

    // address overrun with no END
    clear_ram();
    ram[0]  = ent(4'h1, 4'h0, 12'd2, 12'd1);
    ram[15] = ent(4'h2, 4'h0, 12'd9, 12'd9);
    sb.push_back(mk(1'b1, 1'b0, 4'd7, 12'd1, 12'd2));
    pulse_start();
    chk("start_clears_err2", {63'd0, error}, 64'd0);
    drain("ovr_drain");
    for (int i = 0; i < 200; i++) begin
      if (error) break;
      step();
    end
    chk("overrun_err", {63'd0, error}, 64'd1);
    chk("overrun_addr", 64'(mem_addr), 64'd15);
    n = pulses;
    step(10);
    chk("overrun_no_issue", 64'(pulses), 64'(n));
    sb.push_back(mk(1'b1, 1'b0, 4'd7, 12'd1, 12'd2));
    pulse_tick();
    drain("overrun_restart");
    pulse_stop();
    wait_idle("ovr_idle");

    // stop while a command waits in ISSUE
    ready = 1'b0;
    clear_ram();
    ram[0] = ent(4'h1, 4'h0, 12'd50, 12'd40);
    ram[1] = ent(4'h5, 4'h0, 12'd0, 12'd0);
    pulse_start();
    step(10);
    pulse_stop();
    sb.push_back(mk(1'b1, 1'b0, 4'd7, 12'd40, 12'd50));
    ready = 1'b1;
    step();
    chk("stop_issue_pulse", {63'd0, jump}, 64'd1);
    step(2);
    chk("stop_issue_idle", {63'd0, busy}, 64'd0);
    drain("stop_issue_drain");

    // start and stop together
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("stop_wins", {63'd0, busy}, 64'd0);

`ifdef VECTOR_LIST_FRAME_STATS_EN
    clear_ram();
    ram[0] = ent(4'h5, 4'h0, 12'd0, 12'd0);
    pulse_start();
    step(6);
    pulse_tick();
    step(8);
    pulse_tick();
    step(8);
    chk("fc_three", 64'(frame_count), 64'd3);
    pulse_stop();
    wait_idle("fc_idle");
    pulse_start();
    chk("fc_start_clear", 64'(frame_count), 64'd0);
    pulse_stop();
    wait_idle("fc_idle2");
`endif

    // reset with a pulse in flight
    ready = 1'b0;
    clear_ram();
    ram[0] = ent(4'h1, 4'h0, 12'd3, 12'd3);
    ram[1] = ent(4'h5, 4'h0, 12'd0, 12'd0);
    pulse_start();
    step(8);
    ready = 1'b1;
    step();
    chk("midop_pulse", {63'd0, jump}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("reset_midop", {jump, draw, busy, error, x, y, shift},
        64'd0);
    reset_n = 1'b1;
    ready = 1'b0;
    step(2);
    chk("reset_idle", {63'd0, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_list_player.md
Name: vector_list_player

Overview:
- Command initiator for the vector display control block.
- Fetches 32-bit entries from a display-list RAM through a synchronous read port and decodes them into jump/draw/travel commands with x, y and shift.
- Issues each command as a one-cycle pulse when the control block reports ready.
- Loops the list once per frame, paced by an external frame tick.

Parameters:
- ADDR_W, 10, display-list address width in entries.
- START_ADDR, 0, address of the first entry of every frame.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin playback from START_ADDR
- stop  in  1  one-cycle pulse: halt playback
- frame_tick  in  1  one-cycle frame-rate pulse
- mem_addr  out  ADDR_W  RAM read address
- mem_rd  out  1  RAM read enable; data is valid on mem_data exactly 1 cycle later
- mem_data  in  32  RAM read data
- ready  in  1  control block ready
- jump  out  1  one-cycle jump command
- draw  out  1  one-cycle draw command
- travel  out  1  qualifies draw as a blanked travel move
- x  out  12  target x
- y  out  12  target y
- shift  out  4  line-generator step shift
- busy  out  1  high in every state except IDLE
- error  out  1  sticky: unknown opcode or address overrun
- frame_count  out  16  completed-frame counter (see Optional Feature)

Behaviour:
- Entry format: [31:28] opcode, [27:24] param, [23:12] y, [11:0] x.
- Opcodes:
  - 0 NOP: skip.
  - 1 JUMP: update x and y, pulse jump.
  - 2 DRAW: update x and y, travel=0, pulse draw.
  - 3 TRAVEL: update x and y, travel=1, pulse draw.
  - 4 SHIFT: shift<=param, no pulse.
  - 5 END: end of frame.
  - F HALT: go to IDLE.
  - Any other value: skip and set error.
- Reset: every output is 0. State is IDLE. Address is START_ADDR. tick_pending=0.
- State machine:
  - IDLE → FETCH on start.
  - FETCH: mem_rd=1, mem_addr=ptr; go to WAIT.
  - WAIT: go to DECODE.
  - DECODE: register mem_data. Command opcodes go to ISSUE; NOP, SHIFT and unknown go to FETCH with ptr+1; END goes to FRAME_WAIT; HALT goes to IDLE.
  - ISSUE: wait for ready=1, then register a pulse on jump or draw, high for exactly one cycle. x, y and travel update in that same cycle. ptr<=ptr+1, go to FETCH.
  - FRAME_WAIT: wait for tick_pending=1. When it is set, clear it, set ptr<=START_ADDR and go to FETCH.
- Output holding: x, y, travel and shift stay stable from their update until the next command updates them.
- ready is never sampled in the pulse cycle or the cycle after. The FETCH→WAIT→DECODE path guarantees this, because the control block drops ready on the cycle after it sees the pulse.
- frame_tick is latched into tick_pending in any non-IDLE state.
  - A tick arriving during a frame makes END restart immediately.
  - Multiple ticks collapse into one.
  - tick_pending is cleared in IDLE.
- Address overrun: if ptr=2^ADDR_W-1 is decoded and its entry is not END/HALT, set error and treat the entry as END.
- stop:
  - Takes effect at the next FETCH or FRAME_WAIT, or immediately in IDLE; the block then goes to IDLE.
  - A command already in ISSUE still completes its pulse.
  - x/y/shift are held; busy drops in IDLE.
- start and stop in the same cycle: stop wins.
- start while busy: ignored.
- error clears only on reset or on start.
- reset_n asserted mid-operation: immediate return to reset values, including any pulse in flight.

Optional Feature:
- Macro: VECTOR_LIST_FRAME_STATS_EN.
- When defined:
  - frame_count increments, wrapping at 2^16, on each END decode, including an overrun-forced END.
  - It clears on reset and on start.
- When undefined: the frame_count port is tied to 0 and the counter logic is absent.

Decomposition:
- Shared package vector_pkg holds:
  - Opcode constants OP_NOP, OP_JUMP, OP_DRAW, OP_TRAVEL, OP_SHIFT, OP_END, OP_HALT.
  - Entry field bit positions.
  - State encoding.
- Sub-module vector_entry_decode (combinational): entry in; opcode class, x, y and param out.

Test Plan:
- List {JUMP(100,200), DRAW(300,400), END}, ready tied 1, frame_tick after frame:
  - jump pulses one cycle with x=100, y=200; then draw with travel=0, x=300, y=400.
  - Restart waits for the tick.
- ready held 0 for 50 cycles during ISSUE:
  - no pulse while low; exactly one pulse on the cycle after ready rises; x/y unchanged meanwhile.
- SHIFT param=7 then TRAVEL(5,6):
  - shift=7 before the pulse; draw pulses with travel=1.
- Opcode 9 entry: error=1, the entry is skipped, the following DRAW still issues.
  - start clears error.
- Full RAM with no END (ADDR_W=4): error at address 15, playback restarts at START_ADDR.
- stop during ISSUE:
  - the current pulse completes, then IDLE with busy=0.
  - With the macro: after 3 frames frame_count=3; start resets it to 0.
